// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into single APB transfers,
// returning one response per command with slave-error, misalignment and timeout reporting.
//
// state  | meaning
// IDLE   | cmd_ready high, no APB activity
// SETUP  | PSEL high, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting on PREADY (bounded by TIMEOUT)
// RESP   | rsp_valid high, fields held until rsp_ready
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [1:0]        state_q,       state_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr[1:0] == 2'b00) begin
                        state_d  = ST_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_write ? cmd_wdata : '0;
                    end else begin
                        // Misaligned: answer locally, the bus never sees it.
                        state_d       = ST_RESP;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // wait_cnt_q counts ACCESS cycles already spent before this one.
                    if (wait_cnt_q >= CNT_LAST) begin
                        state_d       = ST_RESP;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Gated by PRESETn so the requester never advertises readiness while held in reset.
    assign cmd_ready   = (state_q == ST_IDLE) && PRESETn;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a small completer memory plus per-scenario tasks
// with hand-computed expectations for latency, APB phase counts and response fields.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        use_mem;
    logic [31:0] prdata_force;
    logic [31:0] mem [16];

    int n_chk;
    int n_pass;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign PRDATA = use_mem ? mem[PADDR[5:2]] : prdata_force;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Issues one command and returns at the negedge where rsp_valid is first seen
    // (rsp_ready still low). lat is in cycles after the accepting edge, -1 if it never came.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input logic serr, input logic [31:0] rforce,
                           input logic mem_mode,
                           output int lat, output int acc, output int psel_cyc,
                           output logic stable, output logic pw, output logic [31:0] pwd,
                           output logic [31:0] rd, output logic er, output logic to);
        int guard;
        int k;
        logic [31:0] a0;
        lat = -1; acc = 0; psel_cyc = 0; stable = 1'b1; pw = 1'bx; pwd = 'x;
        rd = 'x; er = 1'bx; to = 1'bx; a0 = 'x;
        @(negedge PCLK);
        use_mem = mem_mode; prdata_force = rforce;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 20) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        k = 1;
        while (k <= 60) begin
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
                break;
            end
            if (PSEL) begin
                if (psel_cyc == 0) begin
                    a0 = PADDR; pw = PWRITE; pwd = PWDATA;
                end else if (PADDR !== a0 || PWRITE !== pw || PWDATA !== pwd) begin
                    stable = 1'b0;
                end
                psel_cyc++;
            end
            if (PSEL && PENABLE) begin
                acc++;
                PREADY = (acc > waits);
                PSLVERR = serr;
            end else begin
                PREADY = 1'b0;
                PSLVERR = 1'b0;
            end
            @(negedge PCLK);
            k++;
        end
        PREADY = 1'b0;
        PSLVERR = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else n_pass++;
        n_chk++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) $display("FAIL rst_ctrl got %b want 000", {PSEL, PENABLE, PWRITE}); else n_pass++;
        n_chk++; if (PADDR !== 32'h0 || PWDATA !== 32'h0) $display("FAIL rst_paddr_pwdata got %h/%h want 0/0", PADDR, PWDATA); else n_pass++;
        n_chk++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) $display("FAIL rst_rsp_fields got %h %b %b want 0 0 0", rsp_rdata, rsp_err, rsp_timeout); else n_pass++;
        PRESETn = 1'b1;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_write_read();
        int lat, acc, pc;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        run_cmd(1'b1, 32'h4, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b1, lat, acc, pc, st, pw, pwd, rd, er, to);
        consume();
        n_chk++; if (lat !== 4) $display("FAIL wr_latency got %0d want 4", lat); else n_pass++;
        n_chk++; if (pc !== 3 || st !== 1'b1) $display("FAIL wr_psel got cycles %0d stable %b want 3 1", pc, st); else n_pass++;
        n_chk++; if (pw !== 1'b1 || pwd !== 32'hDEADBEEF) $display("FAIL wr_pwrite got %b %h want 1 deadbeef", pw, pwd); else n_pass++;
        n_chk++; if (rd !== 32'h0 || er !== 1'b0 || to !== 1'b0) $display("FAIL wr_rsp got %h %b %b want 0 0 0", rd, er, to); else n_pass++;
        run_cmd(1'b0, 32'h4, 32'h55555555, 0, 1'b0, 32'h0, 1'b1, lat, acc, pc, st, pw, pwd, rd, er, to);
        consume();
        n_chk++; if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (pc !== 2 || st !== 1'b1 || pw !== 1'b0 || pwd !== 32'h0) $display("FAIL rd_phase got cycles %0d stable %b pwrite %b pwdata %h want 2 1 0 0", pc, st, pw, pwd); else n_pass++;
        n_chk++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || to !== 1'b0) $display("FAIL rd_rsp got %h %b %b want deadbeef 0 0", rd, er, to); else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat, acc, pc;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        run_cmd(1'b0, 32'h5, 32'h0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, lat, acc, pc, st, pw, pwd, rd, er, to);
        n_chk++; if (PADDR !== 32'h4) $display("FAIL mis_paddr_kept got %h want 4", PADDR); else n_pass++;
        consume();
        n_chk++; if (lat !== 1) $display("FAIL mis_latency got %0d want 1", lat); else n_pass++;
        n_chk++; if (pc !== 0) $display("FAIL mis_psel got %0d cycles want 0", pc); else n_pass++;
        n_chk++; if (rd !== 32'h0 || er !== 1'b1 || to !== 1'b0) $display("FAIL mis_rsp got %h %b %b want 0 1 0", rd, er, to); else n_pass++;
    endtask

    task automatic test_slverr();
        int lat, acc, pc;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        run_cmd(1'b0, 32'h10, 32'h0, 2, 1'b1, 32'h12345678, 1'b0, lat, acc, pc, st, pw, pwd, rd, er, to);
        consume();
        n_chk++; if (lat !== 5 || acc !== 3) $display("FAIL serr_timing got lat %0d acc %0d want 5 3", lat, acc); else n_pass++;
        n_chk++; if (rd !== 32'h12345678 || er !== 1'b1 || to !== 1'b0) $display("FAIL serr_rsp got %h %b %b want 12345678 1 0", rd, er, to); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, acc, pc;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        run_cmd(1'b0, 32'h20, 32'h0, 1000, 1'b0, 32'hCAFEF00D, 1'b0, lat, acc, pc, st, pw, pwd, rd, er, to);
        n_chk++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL to_bus_idle got %b %b want 0 0", PSEL, PENABLE); else n_pass++;
        consume();
        n_chk++; if (acc !== 16) $display("FAIL to_access_cycles got %0d want 16", acc); else n_pass++;
        n_chk++; if (lat !== 18) $display("FAIL to_latency got %0d want 18", lat); else n_pass++;
        n_chk++; if (rd !== 32'h0 || er !== 1'b1 || to !== 1'b1) $display("FAIL to_rsp got %h %b %b want 0 1 1", rd, er, to); else n_pass++;
        run_cmd(1'b0, 32'h20, 32'h0, 15, 1'b0, 32'hCAFEF00D, 1'b0, lat, acc, pc, st, pw, pwd, rd, er, to);
        consume();
        n_chk++; if (acc !== 16 || lat !== 18) $display("FAIL last_cycle_timing got acc %0d lat %0d want 16 18", acc, lat); else n_pass++;
        n_chk++; if (rd !== 32'hCAFEF00D || er !== 1'b0 || to !== 1'b0) $display("FAIL last_cycle_rsp got %h %b %b want cafef00d 0 0", rd, er, to); else n_pass++;
    endtask

    task automatic test_rsp_hold();
        int lat, acc, pc, guard;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        logic hold_ok;
        run_cmd(1'b0, 32'h30, 32'h0, 0, 1'b1, 32'hA5A50001, 1'b0, lat, acc, pc, st, pw, pwd, rd, er, to);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h0000C0DE;
        use_mem = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A50001 || rsp_err !== 1'b1 ||
                rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || PSEL !== 1'b0) hold_ok = 1'b0;
            @(negedge PCLK);
        end
        n_chk++; if (hold_ok !== 1'b1) $display("FAIL hold_stable got %b want 1", hold_ok); else n_pass++;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) $display("FAIL hold_release got valid %b ready %b psel %b want 0 1 0", rsp_valid, cmd_ready, PSEL); else n_pass++;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n_chk++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'hC) $display("FAIL hold_accept got psel %b penable %b paddr %h want 1 0 c", PSEL, PENABLE, PADDR); else n_pass++;
        PREADY = 1'b1;
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            @(negedge PCLK);
            guard++;
        end
        PREADY = 1'b0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL hold_next_rsp got valid %b err %b want 1 0", rsp_valid, rsp_err); else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat, acc, pc;
        logic st, pw, er, to;
        logic [31:0] pwd, rd;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h11111111;
        PREADY = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        n_chk++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) $display("FAIL mid_in_access got %b %b want 1 1", PSEL, PENABLE); else n_pass++;
        #2 PRESETn = 1'b0;
        #1;
        n_chk++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL mid_async got psel %b penable %b valid %b ready %b want 0 0 0 0", PSEL, PENABLE, rsp_valid, cmd_ready); else n_pass++;
        n_chk++; if (PADDR !== 32'h0 || PWRITE !== 1'b0) $display("FAIL mid_async_addr got %h %b want 0 0", PADDR, PWRITE); else n_pass++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        run_cmd(1'b1, 32'h8, 32'h00000808, 0, 1'b0, 32'h0, 1'b1, lat, acc, pc, st, pw, pwd, rd, er, to);
        consume();
        n_chk++; if (lat !== 3 || pc !== 2 || pw !== 1'b1) $display("FAIL post_rst_wr got lat %0d psel %0d pwrite %b want 3 2 1", lat, pc, pw); else n_pass++;
        n_chk++; if (rd !== 32'h0 || er !== 1'b0 || to !== 1'b0) $display("FAIL post_rst_rsp got %h %b %b want 0 0 0", rd, er, to); else n_pass++;
        n_chk++; if (mem[2] !== 32'h00000808 || mem[4] !== 32'h0) $display("FAIL post_rst_mem got %h %h want 808 0", mem[2], mem[4]); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
        use_mem = 1'b1; prdata_force = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_slverr();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns a simple valid/ready command stream into single APB transfers and returns a one-beat response per command. It sits between the test/control logic and the APB slave register bank, driving the SETUP and ACCESS phases, waiting on PREADY, and reporting slave errors. It also blocks misaligned requests locally and aborts transfers that exceed a bounded wait time.

## Interface
- ADDR_W, 32, width of cmd_addr and PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, maximum ACCESS cycles before abort; must be ≥1
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_W  read data; 0 for writes, misaligned requests and timeouts
- rsp_err  out  1  PSLVERR seen, misaligned address, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address/write data
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1  APB completer response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1, PSEL = PENABLE = 0. On cmd_valid, latch cmd_write/addr/wdata.
  - cmd_addr[1:0] == 0 -> SETUP; load PADDR, PWRITE, PWDATA (PWDATA = 0 for reads); PSEL = 1.
  - Misaligned -> RESP directly with rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0; no APB activity.
- SETUP: exactly one cycle, PSEL = 1, PENABLE = 0 -> ACCESS with PENABLE = 1; clear the wait counter.
- ACCESS: PREADY is sampled only here.
  - PREADY = 1: capture PRDATA into rsp_rdata (reads only; writes give 0) and PSLVERR into rsp_err; rsp_timeout = 0; drop PSEL/PENABLE; -> RESP.
  - PREADY = 0: increment the wait counter. If this is the TIMEOUT-th ACCESS cycle: drop PSEL/PENABLE, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; -> RESP.
  - PREADY = 1 in the final allowed cycle completes normally; completion wins over timeout.
- RESP: rsp_valid = 1, cmd_ready = 0; response fields held stable until rsp_ready -> IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS, then keep their last values.
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset, asynchronous at any point including mid-transfer: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; cmd_ready = 0 while PRESETn is low, then 1 from the first cycle in IDLE. Any in-flight command and pending response are discarded.

## Timing
- Command accepted at edge N: SETUP is visible in cycle N+1, ACCESS in N+2.
- Zero-wait completer: rsp_valid in cycle N+3. One wait state: N+4. Generally N+3+waits.
- Misaligned command accepted at N: rsp_valid in N+1.
- PSEL is low for at least 2 cycles between transfers (RESP plus IDLE); no back-to-back transfers.
- Maximum command throughput is one per 4 cycles, assuming zero-wait and rsp_ready held high.
- cmd_ready and rsp_valid are decoded from the registered state; there is no combinational path from cmd_valid or rsp_ready to any output.

## Test plan
- Write 0xDEADBEEF to 0x4, then read 0x4 -> PSEL held 2+ cycles with PADDR = 0x4 stable, PWRITE = 1 then 0; read rsp_rdata = 0xDEADBEEF, rsp_err = 0; write response rsp_rdata = 0.
- Read 0x5 -> rsp_valid 1 cycle after accept, rsp_err = 1, rsp_timeout = 0; PSEL never asserted.
- Completer asserts PSLVERR on read of 0x10 with PRDATA = 0x12345678 -> rsp_err = 1, rsp_rdata = 0x12345678, rsp_timeout = 0.
- TIMEOUT = 16, PREADY tied low -> exactly 16 cycles with PENABLE = 1, then PSEL = 0, rsp_err = 1, rsp_timeout = 1. Repeat with PREADY high in the 16th ACCESS cycle -> normal completion, rsp_timeout = 0.
- rsp_ready held low 5 cycles after rsp_valid -> response fields constant, cmd_ready = 0, a pending cmd_valid is not accepted; accepted one cycle after rsp_ready.
- PRESETn pulsed low during ACCESS -> PSEL, PENABLE and rsp_valid 0 without waiting for a clock edge; after release, a fresh write to 0x8 completes normally.
